// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction RAM boot loader: FSM states and error codes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which the loader is consuming frame bytes.
  function automatic logic is_busy(input state_e s);
    return (s == StLen0) || (s == StLen1) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: unpacks a length/data/XOR-checksum byte frame into 32-bit words for
// instruction RAM and holds the core in reset until a frame is accepted.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned TIMEOUT  = 65535,
  parameter bit          AUTO_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned ToW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        acc_q, acc_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [ToW-1:0]    to_q, to_d;
  logic              rx_ready_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              accept;
  logic [15:0]       len_w;
  logic              fail;
  logic [1:0]        fail_code;

  assign accept = rx_valid && rx_ready_q;
  assign len_w  = {rx_data, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    acc_d        = acc_q;
    bcnt_d       = bcnt_q;
    wbuf_d       = wbuf_q;
    widx_d       = widx_q;
    to_d         = to_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    fail         = 1'b0;
    fail_code    = ERR_NONE;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d      = StLen0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          err_code_d   = ERR_NONE;
          acc_d        = '0;
          bcnt_d       = '0;
          widx_d       = '0;
          to_d         = '0;
          core_rst_n_d = 1'b0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_lo_d = rx_data;
          acc_d    = acc_q ^ rx_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          n_d   = len_w;
          acc_d = acc_q ^ rx_data;
          if (32'(len_w) > DEPTH) begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
          end else if (len_w == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          acc_d  = acc_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = widx_q[ADDR_W-1:0];
            mem_wdata_d = {rx_data, wbuf_q};
            widx_d      = widx_q + 1'b1;
            if (32'(widx_q) + 32'd1 == 32'(n_q)) state_d = StCsum;
          end else begin
            wbuf_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data == acc_q) begin
            state_d      = StDone;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CSUM;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Inactivity watchdog; an accepted byte always wins over an expiring count.
    if (is_busy(state_q)) begin
      if (accept) begin
        to_d = '0;
      end else if (TIMEOUT != 0) begin
        if (32'(to_q) < TIMEOUT) to_d = to_q + 1'b1;
        if (32'(to_q) + 32'd1 >= TIMEOUT) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
    end

    if (fail) begin
      state_d      = StError;
      error_d      = 1'b1;
      err_code_d   = fail_code;
      core_rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_lo_q     <= '0;
      n_q          <= '0;
      acc_q        <= '0;
      bcnt_q       <= '0;
      wbuf_q       <= '0;
      widx_q       <= '0;
      to_q         <= '0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= AUTO_RUN;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      acc_q        <= acc_d;
      bcnt_q       <= bcnt_d;
      wbuf_q       <= wbuf_d;
      widx_q       <= widx_d;
      to_q         <= to_d;
      rx_ready_q   <= is_busy(state_d);
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign busy       = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length and timeout errors, reset and
// restart behaviour, with write pulses logged and compared against hand-computed values.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, core_rst_n, busy, done, error;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;

  logic        h_rx_ready, h_mem_we, h_core_rst_n, h_busy, h_done, h_error;
  logic [11:0] h_mem_addr;
  logic [31:0] h_mem_wdata;
  logic [1:0]  h_err_code;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          exp_cyc[$];
  logic [7:0]  fr[$];

  imem_loader #(.ADDR_W(12), .DEPTH(4096), .TIMEOUT(16), .AUTO_RUN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  imem_loader #(.ADDR_W(12), .DEPTH(4096), .TIMEOUT(16), .AUTO_RUN(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .start(1'b0), .rx_valid(1'b0), .rx_data(8'h00),
    .rx_ready(h_rx_ready), .mem_we(h_mem_we), .mem_addr(h_mem_addr),
    .mem_wdata(h_mem_wdata), .core_rst_n(h_core_rst_n), .busy(h_busy), .done(h_done),
    .error(h_error), .err_code(h_err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    exp_cyc.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles; wait a bounded time for it to be taken.
  task automatic send(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    last_acc_cyc = cyc;
    check("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_frame(input int gap);
    foreach (fr[i]) begin
      send(fr[i], gap);
      if (i >= 2 && ((i - 2) % 4) == 3) exp_cyc.push_back(last_acc_cyc);
    end
  endtask

  // Checks the two-word frame's writes; timing only when back-to-back bytes were sent.
  task automatic check_two_writes(input string tag, input bit timing);
    logic [31:0] exp_w[2];
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'hDEADBEEF;
    check({tag, "_wr_count"}, wr_addr.size(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), {20'd0, wr_addr[i]}, i);
        check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_w[i]);
        if (timing && i < exp_cyc.size())
          check($sformatf("%s_wr_cycle%0d", tag, i), wr_cyc[i], exp_cyc[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values for both AUTO_RUN settings
    repeat (3) tick();
    rst = 1'b0;
    check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("hold_core_rst_n", {31'd0, h_core_rst_n}, 32'd0);
    check("hold_rx_ready", {31'd0, h_rx_ready}, 32'd0);

    // 2: good two-word frame
    clear_log();
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("start_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    send_frame(0);
    check("good_done", {31'd0, done}, 32'd1);
    check("good_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("good_busy", {31'd0, busy}, 32'd0);
    check("good_error", {31'd0, error}, 32'd0);
    tick();
    check_two_writes("good", 1'b1);

    // 3: same frame, bad checksum
    clear_log();
    do_start();
    check("restart_done_cleared", {31'd0, done}, 32'd0);
    fr[10] = 8'h29;
    send_frame(0);
    tick();
    check_two_writes("csum", 1'b1);
    check("csum_error", {31'd0, error}, 32'd1);
    check("csum_err_code", {30'd0, err_code}, {30'd0, ERR_CSUM});
    check("csum_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("csum_done", {31'd0, done}, 32'd0);

    // 4: N = 4097 exceeds depth
    clear_log();
    do_start();
    check("restart_error_cleared", {31'd0, error}, 32'd0);
    send(8'h01, 0);
    send(8'h10, 0);
    check("len_error", {31'd0, error}, 32'd1);
    check("len_err_code", {30'd0, err_code}, {30'd0, ERR_LEN});
    check("len_busy", {31'd0, busy}, 32'd0);
    tick();
    check("len_no_write", wr_addr.size(), 32'd0);

    // 5a: stall mid-frame; 15 idle cycles survive, the 16th trips the timeout
    clear_log();
    do_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h78, 0);
    repeat (15) tick();
    check("to_not_yet", {31'd0, error}, 32'd0);
    check("to_still_busy", {31'd0, busy}, 32'd1);
    tick();
    check("to_error", {31'd0, error}, 32'd1);
    check("to_err_code", {30'd0, err_code}, {30'd0, ERR_TIMEOUT});

    // 5b: 15-cycle gaps between every byte still complete
    clear_log();
    do_start();
    fr[10] = 8'h28;
    send_frame(15);
    check("gap_done", {31'd0, done}, 32'd1);
    check("gap_error", {31'd0, error}, 32'd0);
    tick();
    check_two_writes("gap", 1'b0);

    // 6a: rst in the same cycle as a word's 4th byte drops the write
    clear_log();
    do_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h12;
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    tick();
    check("midrst_no_write", wr_addr.size(), 32'd0);

    // 6b: start pulsed while loading is ignored
    clear_log();
    do_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h78, 0);
    start = 1'b1;
    send(8'h56, 0);
    start = 1'b0;
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    fr = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    foreach (fr[i]) send(fr[i], 0);
    check("busy_start_done", {31'd0, done}, 32'd1);
    tick();
    check_two_writes("busy_start", 1'b0);

    // 6c: empty frame
    clear_log();
    do_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    tick();
    check("empty_no_write", wr_addr.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot/program loader that owns the core's instruction RAM write port and the core's reset.
- Accepts a byte stream over a valid/ready handshake and unpacks it into 32-bit little-endian words.
- Writes those words into instruction RAM while holding the core in reset.
- Releases the core only after a length and checksum check passes; sits between the host byte link (UART receiver) and the cpu/inst_ram pair.

Parameters:
ADDR_W, 12, instruction RAM word-address width
DEPTH, 4096, instruction RAM depth in words; loads longer than this are rejected
TIMEOUT, 65535, idle cycles allowed between accepted bytes during a load; 0 disables the timeout
AUTO_RUN, 1, 1: core runs the preloaded image after reset; 0: core held in reset until a successful load

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a load
rx_valid  in  1  byte available
rx_data  in  8  byte value
rx_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction RAM write strobe
mem_addr  out  ADDR_W  RAM word address
mem_wdata  out  32  RAM write word
core_rst_n  out  1  drives core rst_n; 0 holds the core in reset
busy  out  1  load in progress
done  out  1  last load succeeded (sticky)
error  out  1  last load failed (sticky)
err_code  out  2  0 none, 1 LEN, 2 CSUM, 3 TIMEOUT

Behaviour:
- Interface: one clock (clk); rst is synchronous, active-high; all outputs are registered.
- Reset: state IDLE.
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, err_code=0.
  - core_rst_n=AUTO_RUN.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4*N data bytes, then CSUM.
  - CSUM = XOR of every preceding frame byte, length bytes included.
- A byte is accepted in a cycle with rx_valid && rx_ready.
- rx_ready=1 exactly in states LEN0, LEN1, DATA, CSUM.
- busy=1 in the same states.
- State transitions:
  - IDLE/DONE/ERROR + start -> LEN0 next cycle.
    - Clears done, error, err_code, the XOR accumulator, the byte counter, the word counter and the timeout counter.
    - core_rst_n=0 from that cycle.
  - start while busy: ignored.
  - LEN0 -> LEN1 on accept.
  - LEN1 on accept:
    - N > DEPTH -> ERROR, err_code=1.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: 2-bit byte counter; byte k goes to word bits [8k+7:8k].
    - On the 4th accepted byte, the cycle after: mem_we=1 for exactly one cycle, mem_addr = word index, mem_wdata = assembled word.
    - Word index then increments.
    - After word N-1 is accepted -> CSUM.
    - The final write pulse overlapping the CSUM state is legal.
  - CSUM on accept: byte == accumulator -> DONE; else -> ERROR, err_code=2.
  - DONE: done=1, core_rst_n=1, both set in the cycle DONE is entered.
  - ERROR: error=1, core_rst_n=0, held until start or rst.
- Timeout:
  - Counter clears on every accepted byte and on start.
  - Counter increments on each busy cycle with no accept.
  - When it reaches TIMEOUT -> ERROR, err_code=3.
- Counter widths:
  - word index ADDR_W+1 bits;
  - N comparison done at 16 bits;
  - timeout counter $clog2(TIMEOUT+1) bits, saturating.
- rst mid-load: IDLE next cycle.
  - Any pending write pulse is dropped; already-written words remain (no rollback).
  - core_rst_n=AUTO_RUN.
- Words beyond N are untouched; mem_addr never exceeds DEPTH-1.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR) and err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT).
- Single module, no sub-module; the byte packer and timeout counter are small enough to stay inline.

Test Plan:
1. Reset with AUTO_RUN=1 -> core_rst_n=1, rx_ready=0, busy=0, done=0, error=0; with AUTO_RUN=0 -> core_rst_n=0.
2. start, then bytes 02 00 78 56 34 12 EF BE AD DE 28 -> two writes: addr0=0x12345678, then addr1=0xDEADBEEF.
   - Each mem_we lasts one cycle, in the cycle after the word's 4th byte.
   - Then done=1, core_rst_n=1, busy=0.
3. Same frame with CSUM 0x29 -> both writes still occur; error=1, err_code=2, core_rst_n=0.
4. Bytes 01 10 (N=4097, DEPTH=4096) -> ERROR with err_code=1 the cycle after the second byte; no mem_we.
5. TIMEOUT=16: send 02 00 78, then hold rx_valid=0 -> ERROR, err_code=3.
   - With 15-cycle gaps between bytes instead, the same frame completes with done=1.
6. Three cases, each checked separately:
   - rst mid-DATA -> IDLE next cycle, rx_ready=0.
   - start pulsed during a load -> no effect.
   - Frame 00 00 00 (N=0) -> done=1 with no writes.
